// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between a fetch port and a data port
module mem_port_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] ACK   = 2'd3;
   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        owner;
   logic        lastGrant;
   logic        latchWe;
   logic [31:0] capData;
   logic        grantMem;
   // owner/lastGrant: 0 = fetch port, 1 = data port; contention favours the port not served last
   assign grantMem  = mem_req & (~if_req | ~lastGrant);
   assign ram_en    = state == ISSUE;
   assign ram_we    = ram_en & latchWe;
   assign if_ack    = (state == ACK) & ~owner;
   assign mem_ack   = (state == ACK) & owner;
   assign busy      = state != IDLE;
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = mem_req & ~mem_ack;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         owner     <= 1'b0;
         lastGrant <= 1'b0;
         latchWe   <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         capData   <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         case (state)
            IDLE: if (if_req | mem_req) begin
               state     <= ISSUE;
               owner     <= grantMem;
               latchWe   <= grantMem & mem_we;
               ram_addr  <= grantMem ? mem_addr : if_addr;
               ram_wdata <= grantMem ? mem_wdata : '0;
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= 4'(MEM_LAT);
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) capData <= ram_rdata;
               // one settling cycle after capture before presenting the result
               if (cnt == 4'd0) begin
                  state <= ACK;
                  if (!owner) if_rdata <= capData;
                  else if (!latchWe) mem_rdata <= capData;
               end
            end
            ACK: begin
               state     <= IDLE;
               lastGrant <= owner;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model plus directed scenarios for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int MEM_LAT = 2;
   localparam int LAT = MEM_LAT + 3;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
   logic [31:0] ram_rdata;
   logic        if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem, busy;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
   int nChecks = 0;
   int nFail = 0;
   always #5 CLK = ~CLK;
   mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
   );
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nChecks++;
      if (a !== e) begin
         nFail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   function automatic logic [31:0] initWord(input logic [31:0] a);
      return a == 32'h10 ? 32'hDEADBEEF : a == 32'h20 ? 32'h20202020 :
             a == 32'h30 ? 32'h30303030 : a ^ 32'hA5A50000;
   endfunction
   // memory seen by the DUT: data valid only in the MEM_LAT-th cycle after the enable cycle
   logic [31:0] ram [logic [31:0]];
   initial begin
      logic        en, we;
      logic [31:0] a, d, pend;
      int          cd;
      cd = 0;
      pend = '0;
      ram_rdata = 32'hBADC0DE0;
      forever begin
         @(negedge CLK);
         en = ram_en; we = ram_we; a = ram_addr; d = ram_wdata;
         @(posedge CLK); #1;
         ram_rdata = 32'hBADC0DE0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) ram_rdata = pend;
         end
         if (en === 1'b1) begin
            if (we) ram[a] = d;
            else begin
               pend = ram.exists(a) ? ram[a] : initWord(a);
               if (MEM_LAT == 1) ram_rdata = pend;
               else cd = MEM_LAT - 1;
            end
         end
      end
   end
   // model: a granted transaction occupies LAT+1 cycles; k counts cycles since grant
   logic [31:0] shadow [logic [31:0]];
   bit          mInit = 0, mActive = 0, mOwner = 0, lastOwner = 0, eWe = 0;
   int          k = 0;
   logic [31:0] eAddr = '0, eWd = '0, eIfR = '0, eMemR = '0, rd = '0;
   initial forever begin
      @(posedge CLK);
      if (RST) begin
         mInit = 1; mActive = 0; lastOwner = 0;
         eIfR = '0; eMemR = '0;
      end else if (mInit) begin
         if (mActive) begin
            k++;
            if (k == LAT + 1) begin
               mActive = 0;
               lastOwner = mOwner;
            end else if (k == LAT && !eWe) begin
               if (mOwner) eMemR = rd;
               else eIfR = rd;
            end
         end else if (if_req || mem_req) begin
            mOwner = (if_req && mem_req) ? !lastOwner : mem_req;
            eAddr = mOwner ? mem_addr : if_addr;
            eWe = mOwner && mem_we;
            eWd = mem_wdata;
            rd = shadow.exists(eAddr) ? shadow[eAddr] : initWord(eAddr);
            if (eWe) shadow[eAddr] = eWd;
            mActive = 1;
            k = 1;
         end
      end
   end
   initial forever begin
      bit xEn, xIfAck, xMemAck;
      @(negedge CLK);
      if (mInit) begin
         xEn = mActive && k == 1;
         xIfAck = mActive && k == LAT && !mOwner;
         xMemAck = mActive && k == LAT && mOwner;
         chk("ram_en", ram_en, xEn);
         chk("ram_we", ram_we, xEn && eWe);
         chk("if_ack", if_ack, xIfAck);
         chk("mem_ack", mem_ack, xMemAck);
         chk("busy", busy, mActive);
         chk("if_rdata", if_rdata, eIfR);
         chk("mem_rdata", mem_rdata, eMemR);
         chk("stall_if", stall_if, if_req && !xIfAck);
         chk("stall_mem", stall_mem, mem_req && !xMemAck);
         if (xEn) begin
            chk("ram_addr", ram_addr, eAddr);
            if (eWe) chk("ram_wdata", ram_wdata, eWd);
         end
      end
   end
   int rel;
   task automatic startT(); rel = -1; endtask
   task automatic at(input int r);
      while (rel < r) begin
         @(negedge CLK);
         rel++;
      end
   endtask
   task automatic toCycle(input int r);
      at(r - 1);
      @(posedge CLK); #1;
   endtask
   task automatic doReset();
      RST = 1;
      repeat (2) @(posedge CLK);
      #1 RST = 0;
   endtask
   initial begin
      @(posedge CLK); #1;
      if_req = 1;
      @(negedge CLK);
      chk("rst busy", busy, 0);
      chk("rst ram_en", ram_en, 0);
      chk("rst ram_addr", ram_addr, 0);
      chk("rst ram_wdata", ram_wdata, 0);
      chk("rst if_rdata", if_rdata, 0);
      chk("rst stall_if", stall_if, 1);
      chk("rst stall_mem", stall_mem, 0);
      @(posedge CLK); #1;
      RST = 0; if_req = 0;
      repeat (2) @(posedge CLK); #1;
      // lone fetch
      if_req = 1; if_addr = 32'h10; startT();
      at(0); chk("fetch stall T", stall_if, 1);
      at(1); chk("fetch ram_en", ram_en, 1); chk("fetch ram_addr", ram_addr, 32'h10);
      at(4); chk("fetch early ack", if_ack, 0); chk("fetch stall T+4", stall_if, 1);
      at(5); chk("fetch ack", if_ack, 1); chk("fetch data", if_rdata, 32'hDEADBEEF);
      toCycle(6); if_req = 0;
      at(6); chk("fetch idle", busy, 0);
      // contention right after reset: data port wins first
      @(posedge CLK); #1; doReset();
      if_req = 1; if_addr = 32'h20; mem_req = 1; mem_addr = 32'h30; mem_we = 0; startT();
      at(1); chk("cont mem addr", ram_addr, 32'h30);
      at(5); chk("cont mem ack", mem_ack, 1); chk("cont mem data", mem_rdata, 32'h30303030);
      chk("cont no if ack", if_ack, 0);
      toCycle(6); mem_req = 0;
      at(6); chk("cont idle gap", busy, 0);
      at(7); chk("cont if en", ram_en, 1); chk("cont if addr", ram_addr, 32'h20);
      at(11); chk("cont if ack", if_ack, 1); chk("cont if data", if_rdata, 32'h20202020);
      toCycle(12); if_req = 0;
      // sustained contention alternates every LAT+1 cycles
      @(posedge CLK); #1; doReset();
      if_req = 1; if_addr = 32'h10; mem_req = 1; mem_addr = 32'h30; startT();
      at(5); chk("alt ack1 mem", mem_ack, 1);
      at(11); chk("alt ack2 if", if_ack, 1); chk("alt ack2 not mem", mem_ack, 0);
      at(17); chk("alt ack3 mem", mem_ack, 1);
      at(23); chk("alt ack4 if", if_ack, 1); chk("alt ack4 data", if_rdata, 32'hDEADBEEF);
      toCycle(24); if_req = 0; mem_req = 0;
      // store leaves load data untouched, then read it back
      toCycle(25); mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_wdata = 32'h12345678; startT();
      at(1); chk("st ram_en", ram_en, 1); chk("st ram_we", ram_we, 1);
      chk("st ram_addr", ram_addr, 32'h40); chk("st ram_wdata", ram_wdata, 32'h12345678);
      at(5); chk("st ack", mem_ack, 1); chk("st rdata kept", mem_rdata, 32'h30303030);
      toCycle(6); mem_req = 0; mem_we = 0;
      toCycle(7); mem_req = 1; startT();
      at(5); chk("ld ack", mem_ack, 1); chk("ld data", mem_rdata, 32'h12345678);
      toCycle(6); mem_req = 0;
      // reset while waiting aborts the fetch
      toCycle(7); if_req = 1; if_addr = 32'h50; startT();
      toCycle(3); RST = 1; if_req = 0;
      toCycle(4); RST = 0;
      at(4); chk("abort busy", busy, 0); chk("abort if_rdata", if_rdata, 0);
      chk("abort mem_rdata", mem_rdata, 0);
      at(8); chk("abort no ack", if_ack, 0); chk("abort no en", ram_en, 0);
      toCycle(10); if_req = 1; if_addr = 32'h10; startT();
      at(1); chk("post ram_en", ram_en, 1);
      at(4); chk("post early ack", if_ack, 0);
      at(5); chk("post ack", if_ack, 1); chk("post data", if_rdata, 32'hDEADBEEF);
      toCycle(6); if_req = 0;
      repeat (3) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
